// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Holds the memory-op encoding, the FSM states and the address-error bit positions.
package mem_pkg;

    localparam int MEMOP_W  = 4;
    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;

    typedef enum logic [MEMOP_W-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_t;

    function automatic logic op_is_load(input logic [MEMOP_W-1:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: op_is_load = 1'b1;
            default:                                  op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [MEMOP_W-1:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: op_is_store = 1'b1;
            default:                op_is_store = 1'b0;
        endcase
    endfunction

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
    function automatic logic op_misaligned(input logic [MEMOP_W-1:0] op, input logic [1:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: op_misaligned = a[0];
            MEM_LW, MEM_SW:          op_misaligned = (a != 2'b00);
            default:                 op_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and little-endian extract/extension for loads.
// Purely combinational; the caller registers whatever it needs.
module mem_align
    import mem_pkg::*;
(
    input  logic [MEMOP_W-1:0] op,
    input  logic [1:0]         addr_lo,
    input  logic [31:0]        sdata,
    input  logic [31:0]        rdata,
    output logic [3:0]         be,
    output logic [31:0]        wdata,
    output logic [31:0]        ldata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store byte enables and lane-replicated write data.
    always_comb begin
        be    = 4'b1111;
        wdata = sdata;
        case (op)
            MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            MEM_SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = sdata;
            end
        endcase
    end

    // Byte/half lane selection from the returned word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign or zero extension of the selected lane.
    always_comb begin
        case (op)
            MEM_LB:  ldata = {{24{byte_s[7]}}, byte_s};
            MEM_LBU: ldata = {24'd0, byte_s};
            MEM_LH:  ldata = {{16{half_s[15]}}, half_s};
            MEM_LHU: ldata = {16'd0, half_s};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: one req/ack bus access per memory op, stalling the pipeline
// until load data is captured; non-memory ops and faulting ops pass straight through.
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               advance,
    input  logic [MEMOP_W-1:0] ex_memop,
    input  logic [ADDR_W-1:0]  ex_addr,
    input  logic [31:0]        ex_sdata,
    input  logic [4:0]         ex_wd,
    input  logic               ex_wreg,
    input  logic [31:0]        ex_wdata,
    input  logic [31:0]        ex_except_type,
    output logic [4:0]         mem_wd,
    output logic               mem_wreg,
    output logic [31:0]        mem_wdata,
    output logic [31:0]        mem_except_type,
    output logic [31:0]        mem_mem_addr,
    output logic               stall_req,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [3:0]         dbus_be,
    output logic [ADDR_W-1:0]  dbus_addr,
    output logic [DATA_W-1:0]  dbus_wdata,
    input  logic [DATA_W-1:0]  dbus_rdata,
    input  logic               dbus_ack
);

    mem_state_t  state_r;
    mem_state_t  state_nxt_s;
    logic [31:0] result_r;

    logic        is_load_s;
    logic        is_store_s;
    logic        is_mem_s;
    logic        misalign_s;
    logic        access_ok_s;
    logic        issue_s;
    logic [31:0] exc_bits_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ldata_s;

    assign is_load_s   = op_is_load(ex_memop);
    assign is_store_s  = op_is_store(ex_memop);
    assign is_mem_s    = is_load_s | is_store_s;
    assign misalign_s  = op_misaligned(ex_memop, ex_addr[1:0]);
    assign access_ok_s = is_mem_s & ~misalign_s & (ex_except_type == 32'd0);
    assign issue_s     = (state_r == ST_IDLE) & access_ok_s & ~flush;

    mem_align u_align (
        .op      (ex_memop),
        .addr_lo (ex_addr[1:0]),
        .sdata   (ex_sdata),
        .rdata   (dbus_rdata),
        .be      (be_s),
        .wdata   (wdata_s),
        .ldata   (ldata_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an ack coinciding with flush drops the data.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_ok_s && !flush) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dbus_ack) begin
                    state_nxt_s = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (advance || flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (dbus_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus request registers: loaded on issue, held until the ack of that access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_be    <= 4'd0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
        end else if (issue_s) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store_s;
            dbus_be    <= be_s;
            dbus_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            dbus_wdata <= wdata_s;
        end else if (((state_r == ST_BUSY) || (state_r == ST_DRAIN)) && dbus_ack) begin
            dbus_req   <= 1'b0;
        end
    end

    // Load result capture; only a non-flushed ack in BUSY is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= 32'd0;
        end else if ((state_r == ST_BUSY) && dbus_ack && !flush) begin
            result_r <= ldata_s;
        end
    end

    // Address-error bits merged into the exception word.
    always_comb begin
        exc_bits_s = 32'd0;
        if (misalign_s && is_load_s) begin
            exc_bits_s[EXC_ADEL] = 1'b1;
        end else if (misalign_s && is_store_s) begin
            exc_bits_s[EXC_ADES] = 1'b1;
        end else begin
            exc_bits_s = 32'd0;
        end
    end

    assign mem_wd          = ex_wd;
    assign mem_mem_addr    = 32'(ex_addr);
    assign mem_except_type = ex_except_type | exc_bits_s;

    // Pipeline-facing outputs.
    always_comb begin
        stall_req = 1'b0;
        mem_wreg  = ex_wreg & ~misalign_s;
        if (is_load_s && access_ok_s) begin
            mem_wdata = result_r;
        end else begin
            mem_wdata = ex_wdata;
        end
        case (state_r)
            ST_IDLE:  stall_req = access_ok_s & ~flush;
            ST_BUSY:  stall_req = 1'b1;
            ST_DONE:  stall_req = 1'b0;
            ST_DRAIN: stall_req = is_mem_s;
            default:  stall_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a driver pushes expected retire/bus records into queues,
// independent monitors pop and compare whenever the DUT retires an op or starts a bus access.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        advance;
    logic [3:0]  ex_memop;
    logic [31:0] ex_addr;
    logic [31:0] ex_sdata;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_except_type;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_except_type;
    logic [31:0] mem_mem_addr;
    logic        stall_req;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .advance(advance),
        .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_except_type(ex_except_type),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_except_type(mem_except_type), .mem_mem_addr(mem_mem_addr),
        .stall_req(stall_req),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wdata;
        logic        wdchk;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] exc;
        logic [31:0] addr;
    } ret_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        wchk;
    } bus_t;

    ret_t        ret_q[$];
    bus_t        bus_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        present = 1'b0;
    int          ack_delay = 1;
    logic [31:0] rd_val = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Bus slave: ack after ack_delay request cycles, one-cycle pulse.
    initial begin
        int cnt;
        cnt = 0;
        dbus_ack = 1'b0;
        dbus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (dbus_ack) begin
                dbus_ack = 1'b0;
                cnt = 0;
            end else if (dbus_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    dbus_ack = 1'b1;
                    dbus_rdata = rd_val;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Retire monitor: an op leaves MEM when it is present, not stalled and advance is high.
    initial begin
        ret_t e;
        forever begin
            @(negedge clk);
            if (rst && present && advance && !stall_req) begin
                if (ret_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire_unexpected actual=%h expected=none", mem_wdata);
                end else begin
                    e = ret_q.pop_front();
                    if (e.wdchk) chk("ret_wdata", mem_wdata, e.wdata);
                    chk("ret_wreg", {31'd0, mem_wreg}, {31'd0, e.wreg});
                    chk("ret_wd", {27'd0, mem_wd}, {27'd0, e.wd});
                    chk("ret_except", mem_except_type, e.exc);
                    chk("ret_mem_addr", mem_mem_addr, e.addr);
                end
            end
        end
    end

    // Bus monitor: compare each new request, then check it stays stable while held.
    initial begin
        logic prev;
        bus_t cur;
        prev = 1'b0;
        cur = '{32'd0, 4'd0, 1'b0, 32'd0, 1'b0};
        forever begin
            @(negedge clk);
            if (dbus_req && !prev) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected actual=%h expected=none", dbus_addr);
                end else begin
                    cur = bus_q.pop_front();
                    chk("bus_addr", dbus_addr, cur.addr);
                    chk("bus_be", {28'd0, dbus_be}, {28'd0, cur.be});
                    chk("bus_we", {31'd0, dbus_we}, {31'd0, cur.we});
                    if (cur.wchk) chk("bus_wdata", dbus_wdata, cur.wdata);
                end
            end else if (dbus_req && prev) begin
                chk("bus_hold_addr", dbus_addr, cur.addr);
                chk("bus_hold_ctl", {27'd0, dbus_we, dbus_be}, {27'd0, cur.we, cur.be});
                if (cur.wchk) chk("bus_hold_wdata", dbus_wdata, cur.wdata);
            end
            prev = dbus_req;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] wdata, input logic wreg, input logic [31:0] exc,
                         input logic [31:0] rd, input int dly, input int hold,
                         input logic bus, input logic [3:0] ebe, input logic [31:0] ebw,
                         input logic [31:0] ewd, input logic ewchk, input logic ewreg,
                         input logic [31:0] eexc, output int stalls);
        logic we_e;
        we_e = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
        ex_memop = op;
        ex_addr = addr;
        ex_sdata = sdata;
        ex_wdata = wdata;
        ex_wreg = wreg;
        ex_wd = 5'(op) + 5'd2;
        ex_except_type = exc;
        rd_val = rd;
        ack_delay = dly;
        advance = (hold == 0);
        present = 1'b1;
        ret_q.push_back('{ewd, ewchk, ewreg, 5'(op) + 5'd2, eexc, addr});
        if (bus) bus_q.push_back('{{addr[31:2], 2'b00}, ebe, we_e, ebw, we_e});
        stalls = 0;
        @(negedge clk);
        while (stall_req && stalls < 60) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 60) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout actual=%0d expected<60", stalls);
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("done_hold_stall", {31'd0, stall_req}, 32'd0);
            end
            @(posedge clk);
            #1 advance = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        present = 1'b0;
        ex_memop = MEM_NONE;
        ex_except_type = 32'd0;
        advance = 1'b1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        @(negedge clk);
        while (!dbus_req && n < 10) begin
            n++;
            @(negedge clk);
        end
        if (!dbus_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=0 expected=1");
        end
    endtask

    initial begin
        int st;
        rst = 1'b1;
        flush = 1'b0;
        advance = 1'b1;
        ex_memop = MEM_NONE;
        ex_addr = 32'd0;
        ex_sdata = 32'd0;
        ex_wd = 5'd7;
        ex_wreg = 1'b1;
        ex_wdata = 32'h1111_2222;
        ex_except_type = 32'd0;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_we", {31'd0, dbus_we}, 32'd0);
        chk("rst_be", {28'd0, dbus_be}, 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h1111_2222);
        chk("rst_mem_wd", {27'd0, mem_wd}, 32'd7);
        @(posedge clk);
        #1 rst = 1'b1;

        // Non-memory op passes through.
        issue(MEM_NONE, 32'h40, 32'd0, 32'hCAFE_F00D, 1'b1, 32'd0, 32'd0, 1, 0,
              1'b0, 4'd0, 32'd0, 32'hCAFE_F00D, 1'b1, 1'b1, 32'd0, st);
        chk("nonmem_stall", st, 32'd0);
        // LW with ack on the third request cycle.
        issue(MEM_LW, 32'h1000, 32'd0, 32'h5555, 1'b1, 32'd0, 32'hDEAD_BEEF, 3, 0,
              1'b1, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'd0, st);
        chk("lw_stall_cycles", st, 32'd4);
        issue(MEM_LB, 32'h1003, 32'd0, 32'd0, 1'b1, 32'd0, 32'h80FF_FF00, 1, 0,
              1'b1, 4'hF, 32'd0, 32'hFFFF_FF80, 1'b1, 1'b1, 32'd0, st);
        chk("lb_stall_cycles", st, 32'd2);
        // LBU held in DONE for two cycles before advance.
        issue(MEM_LBU, 32'h1003, 32'd0, 32'd0, 1'b1, 32'd0, 32'h80FF_FF00, 1, 2,
              1'b1, 4'hF, 32'd0, 32'h0000_0080, 1'b1, 1'b1, 32'd0, st);
        issue(MEM_LH, 32'h1002, 32'd0, 32'd0, 1'b1, 32'd0, 32'h8001_1234, 2, 0,
              1'b1, 4'hF, 32'd0, 32'hFFFF_8001, 1'b1, 1'b1, 32'd0, st);
        issue(MEM_LHU, 32'h1000, 32'd0, 32'd0, 1'b1, 32'd0, 32'h8001_9234, 2, 0,
              1'b1, 4'hF, 32'd0, 32'h0000_9234, 1'b1, 1'b1, 32'd0, st);
        // Stores.
        issue(MEM_SH, 32'h2002, 32'h1234_ABCD, 32'h77, 1'b0, 32'd0, 32'd0, 1, 0,
              1'b1, 4'b1100, 32'hABCD_ABCD, 32'h77, 1'b1, 1'b0, 32'd0, st);
        issue(MEM_SB, 32'h2011, 32'h0000_005A, 32'h78, 1'b0, 32'd0, 32'd0, 1, 0,
              1'b1, 4'b0010, 32'h5A5A_5A5A, 32'h78, 1'b1, 1'b0, 32'd0, st);
        issue(MEM_SW, 32'h2020, 32'h0102_0304, 32'h79, 1'b0, 32'd0, 32'd0, 2, 0,
              1'b1, 4'b1111, 32'h0102_0304, 32'h79, 1'b1, 1'b0, 32'd0, st);
        chk("sw_stall_cycles", st, 32'd3);
        // Address errors and earlier exceptions suppress the access.
        issue(MEM_LW, 32'h3001, 32'd0, 32'd0, 1'b1, 32'd0, 32'd0, 1, 0,
              1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0010, st);
        chk("adel_stall", st, 32'd0);
        issue(MEM_SH, 32'h3003, 32'h55, 32'h66, 1'b0, 32'd0, 32'd0, 1, 0,
              1'b0, 4'd0, 32'd0, 32'h66, 1'b1, 1'b0, 32'h0000_0020, st);
        issue(MEM_SW, 32'h3002, 32'h55, 32'h67, 1'b0, 32'h1, 32'd0, 1, 0,
              1'b0, 4'd0, 32'd0, 32'h67, 1'b1, 1'b0, 32'h0000_0021, st);
        issue(MEM_LW, 32'h1000, 32'd0, 32'd0, 1'b0, 32'h400, 32'd0, 1, 0,
              1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0400, st);
        chk("exc_stall", st, 32'd0);

        // LW flushed in BUSY, then SW waits for the drain ack.
        ex_memop = MEM_LW;
        ex_addr = 32'h4000;
        ex_wreg = 1'b1;
        ack_delay = 3;
        rd_val = 32'h9999_9999;
        present = 1'b0;
        bus_q.push_back('{32'h4000, 4'hF, 1'b0, 32'd0, 1'b0});
        wait_req();
        chk("flush_busy_stall", {31'd0, stall_req}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        issue(MEM_SW, 32'h5000, 32'hA5A5_0F0F, 32'd0, 1'b0, 32'd0, 32'd0, 1, 0,
              1'b1, 4'hF, 32'hA5A5_0F0F, 32'd0, 1'b1, 1'b0, 32'd0, st);
        chk("sw_after_drain_stall", st, 32'd3);

        // Reset while BUSY drops the request asynchronously.
        ex_memop = MEM_LW;
        ex_addr = 32'h6000;
        ack_delay = 8;
        present = 1'b0;
        bus_q.push_back('{32'h6000, 4'hF, 1'b0, 32'd0, 1'b0});
        wait_req();
        #2 rst = 1'b0;
        #1 chk("rst_async_req", {31'd0, dbus_req}, 32'd0);
        ex_memop = MEM_NONE;
        #1 chk("rst_async_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'd0, dbus_req}, 32'd0);
        chk("post_rst_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        issue(MEM_LW, 32'h7004, 32'd0, 32'd0, 1'b1, 32'd0, 32'h0BAD_F00D, 1, 0,
              1'b1, 4'hF, 32'd0, 32'h0BAD_F00D, 1'b1, 1'b1, 32'd0, st);
        chk("recover_stall", st, 32'd2);

        repeat (3) @(negedge clk);
        chk("ret_q_empty", ret_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
